// File: rtl/sl_fifo_pkg.sv
// Shared types and widths for the host side of the 34-bit SL FIFO link.
// A link word is {addr[1:0], data[31:0]} in both directions.
package sl_fifo_pkg;

    localparam int WORD_W    = 34;
    localparam int PAYLOAD_W = 32;
    localparam int CFG_W     = 16;

    // Register selector carried in the top two bits of every link word.
    typedef enum logic [1:0] {
        CFG    = 2'd0,
        DATA   = 2'd1,
        STATUS = 2'd2,
        CHAN   = 2'd3
    } addr_e;

    typedef struct packed {
        addr_e                 addr;
        logic [PAYLOAD_W-1:0]  data;
    } fifo_word_t;

endpackage

// File: rtl/sl_echo_watchdog.sv
// Config echo watchdog: once a config word has been pushed to the far end,
// waits for the matching config echo on the response stream. Flags a
// value mismatch (err_bits[0]) or no echo within ECHO_TIMEOUT cycles
// (err_bits[1]). Both flags are sticky until clr.
module sl_echo_watchdog
    import sl_fifo_pkg::*;
#(
    parameter int ECHO_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [CFG_W-1:0] arm_value,
    input  logic             echo,
    input  logic [CFG_W-1:0] echo_value,
    input  logic             clr,
    output logic [1:0]       err_bits
);

    localparam int CNT_W = $clog2(ECHO_TIMEOUT + 1);

    logic             armed;
    logic [CFG_W-1:0] expect_value;
    logic [CNT_W-1:0] count;

    // Arm / disarm, count armed cycles, and latch sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed        <= 1'b0;
            expect_value <= '0;
            count        <= '0;
            err_bits     <= '0;
        end else begin
            // Clear first so an error detected in the same cycle still sticks.
            if (clr) begin
                err_bits <= '0;
            end
            if (armed && echo && (echo_value != expect_value)) begin
                err_bits[0] <= 1'b1;
            end

            if (arm) begin
                // A fresh config push always restarts the wait.
                armed        <= 1'b1;
                expect_value <= arm_value;
                count        <= '0;
            end else if (armed && echo) begin
                armed <= 1'b0;
            end else if (armed) begin
                if (count == CNT_W'(ECHO_TIMEOUT - 1)) begin
                    err_bits[1] <= 1'b1;
                    armed       <= 1'b0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sl_host_fifo_bridge.sv
// Host-side bridge for the SL FIFO link. Host writes become command words
// in a one-deep holding register that drains into the command FIFO; response
// words are popped as soon as they appear and update per-channel shadows
// that serve all host reads locally.
// Optional config echo checking is compiled in with `define SL_ECHO_CHECK_EN.
module sl_host_fifo_bridge
    import sl_fifo_pkg::*;
#(
    parameter int WORD_W       = sl_fifo_pkg::WORD_W,
    parameter int ECHO_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_write,
    input  logic [1:0]        host_req_addr,
    input  logic [31:0]       host_req_wdata,
    output logic              host_rsp_valid,
    output logic [31:0]       host_rsp_rdata,
    input  logic              cmd_fifo_full,
    output logic              cmd_fifo_inc,
    output logic [WORD_W-1:0] cmd_fifo_data,
    input  logic              resp_fifo_empty,
    input  logic [WORD_W-1:0] resp_fifo_data,
    output logic              resp_fifo_inc,
    output logic              cur_channel,
    output logic              irq_data,
    output logic              irq_status
);

    fifo_word_t       cmd_word;
    fifo_word_t       resp_word;
    logic             cmd_vld;
    logic             req_accept;
    logic             wr_accept;
    logic             rd_accept;
    logic             push;
    logic             pop;
    logic [31:0]      wdata_fwd;
    logic [31:0]      rd_mux;
    logic [1:0]       err_bits;

    logic [CFG_W-1:0] cfg_sh    [2];
    logic [CFG_W-1:0] status_sh [2];
    logic [31:0]      rx_data;

    // Handshakes. Reset blocks new requests, pushes and pops so nothing
    // crosses the link while state is being cleared.
    assign host_req_ready = !cmd_vld && !rst;
    assign req_accept     = host_req_valid && host_req_ready;
    assign wr_accept      = req_accept && host_req_write;
    assign rd_accept      = req_accept && !host_req_write;
    assign push           = cmd_vld && !cmd_fifo_full && !rst;
    assign cmd_fifo_inc   = push;
    assign cmd_fifo_data  = cmd_word;
    assign pop            = !resp_fifo_empty && !rst;
    assign resp_fifo_inc  = pop;
    assign resp_word      = resp_fifo_data;

`ifdef SL_ECHO_CHECK_EN
    logic err_clr;

    // A channel write with bit 31 set clears the echo errors; bit 31 never
    // reaches the far end.
    assign err_clr   = wr_accept && (addr_e'(host_req_addr) == CHAN) && host_req_wdata[31];
    assign wdata_fwd = (addr_e'(host_req_addr) == CHAN) ? {1'b0, host_req_wdata[30:0]}
                                                        : host_req_wdata;

    sl_echo_watchdog #(
        .ECHO_TIMEOUT (ECHO_TIMEOUT)
    ) u_echo_watchdog (
        .clk        (clk),
        .rst        (rst),
        .arm        (push && (cmd_word.addr == CFG)),
        .arm_value  (cmd_word.data[CFG_W-1:0]),
        .echo       (pop && (resp_word.addr == CFG)),
        .echo_value (resp_word.data[CFG_W-1:0]),
        .clr        (err_clr),
        .err_bits   (err_bits)
    );
`else
    logic unused_echo_timeout;

    assign wdata_fwd           = host_req_wdata;
    assign err_bits            = 2'b00;
    assign unused_echo_timeout = (ECHO_TIMEOUT != 0);
`endif

    // Command holding register: load on an accepted write, drain on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld  <= 1'b0;
            cmd_word <= '0;
        end else if (wr_accept) begin
            // NOTE: non-blocking assignments so every flop here samples pre-edge values.
            cmd_vld  <= 1'b1;
            cmd_word <= '{addr: addr_e'(host_req_addr), data: wdata_fwd};
        end else if (push) begin
            cmd_vld  <= 1'b0;
        end
    end

    // Read data selection from the local shadows of the current channel.
    always_comb begin
        // NOTE: default first keeps this block latch-free for every address.
        rd_mux = '0;
        case (addr_e'(host_req_addr))
            CFG:     rd_mux = {16'b0, cfg_sh[cur_channel]};
            DATA:    rd_mux = rx_data;
            STATUS:  rd_mux = {16'b0, status_sh[cur_channel]};
            CHAN:    rd_mux = {err_bits, 29'b0, cur_channel};
            default: rd_mux = '0;
        endcase
    end

    // Read response: one-cycle valid pulse carrying the pre-update shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rsp_valid <= 1'b0;
            host_rsp_rdata <= '0;
        end else begin
            host_rsp_valid <= rd_accept;
            if (rd_accept) begin
                host_rsp_rdata <= rd_mux;
            end
        end
    end

    // Response decode: update shadows and raise event pulses for each popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow arrays are plain flops, not RAM, so they are
            // reset here and the host always reads 0 after reset.
            cfg_sh      <= '{default: '0};
            status_sh   <= '{default: '0};
            rx_data     <= '0;
            cur_channel <= 1'b0;
            irq_data    <= 1'b0;
            irq_status  <= 1'b0;
        end else begin
            irq_data   <= pop && (resp_word.addr == DATA);
            irq_status <= pop && (resp_word.addr == STATUS);
            if (pop) begin
                case (resp_word.addr)
                    CFG:     cfg_sh[cur_channel]    <= resp_word.data[CFG_W-1:0];
                    DATA:    rx_data                <= resp_word.data;
                    STATUS:  status_sh[cur_channel] <= resp_word.data[CFG_W-1:0];
                    CHAN:    cur_channel            <= resp_word.data[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sl_host_fifo_bridge.sv
// Self-checking bench for sl_host_fifo_bridge. A negedge monitor compares
// every command push and every read response against scoreboard queues
// filled when the stimulus is driven. Works with or without SL_ECHO_CHECK_EN.
module tb_sl_host_fifo_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_write;
    logic [1:0]  host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_rdata;
    logic        cmd_fifo_full;
    logic        cmd_fifo_inc;
    logic [33:0] cmd_fifo_data;
    logic        resp_fifo_empty;
    logic [33:0] resp_fifo_data;
    logic        resp_fifo_inc;
    logic        cur_channel;
    logic        irq_data;
    logic        irq_status;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int irq_data_cnt = 0;
    int irq_status_cnt = 0;

    logic [33:0] cmd_q [$];
    logic [31:0] rsp_q [$];

    typedef struct {
        logic        do_resp;
        logic [33:0] resp;
        logic [1:0]  raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

`ifdef SL_ECHO_CHECK_EN
    localparam logic [31:0] EXP_TIMEOUT_ERR  = 32'h8000_0000;
    localparam logic [31:0] EXP_MISMATCH_ERR = 32'h4000_0000;
`else
    localparam logic [31:0] EXP_TIMEOUT_ERR  = 32'h0000_0000;
    localparam logic [31:0] EXP_MISMATCH_ERR = 32'h0000_0000;
`endif

    sl_host_fifo_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_write  (host_req_write),
        .host_req_addr   (host_req_addr),
        .host_req_wdata  (host_req_wdata),
        .host_rsp_valid  (host_rsp_valid),
        .host_rsp_rdata  (host_rsp_rdata),
        .cmd_fifo_full   (cmd_fifo_full),
        .cmd_fifo_inc    (cmd_fifo_inc),
        .cmd_fifo_data   (cmd_fifo_data),
        .resp_fifo_empty (resp_fifo_empty),
        .resp_fifo_data  (resp_fifo_data),
        .resp_fifo_inc   (resp_fifo_inc),
        .cur_channel     (cur_channel),
        .irq_data        (irq_data),
        .irq_status      (irq_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (cmd_fifo_inc) begin
            push_cnt++;
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push actual=%0h required=none", cmd_fifo_data);
            end else begin
                check("cmd_word", {30'b0, cmd_fifo_data}, {30'b0, cmd_q.pop_front()});
            end
        end
        if (host_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%0h required=none", host_rsp_rdata);
            end else begin
                check("rsp_rdata", {32'b0, host_rsp_rdata}, {32'b0, rsp_q.pop_front()});
            end
        end
        if (resp_fifo_inc) pop_cnt++;
        if (irq_data)      irq_data_cnt++;
        if (irq_status)    irq_status_cnt++;
    end

    // Issue one host request; called at posedge+1, returns at posedge+1.
    task automatic host_req(input bit wr, input logic [1:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd);
        int n = 0;
        logic [31:0] fwd;
        host_req_valid = 1'b1;
        host_req_write = wr;
        host_req_addr  = a;
        host_req_wdata = d;
        while (!host_req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!host_req_ready) begin
            check("req_accept_timeout", {63'b0, host_req_ready}, 64'd1);
            host_req_valid = 1'b0;
            return;
        end
        fwd = d;
`ifdef SL_ECHO_CHECK_EN
        if (wr && a == 2'd3) fwd[31] = 1'b0;
`endif
        if (wr) cmd_q.push_back({a, fwd});
        else    rsp_q.push_back(exp_rd);
        @(posedge clk); #1;
        host_req_valid = 1'b0;
        if (!wr)                 check("rsp_latency", {63'b0, host_rsp_valid}, 64'd1);
        else if (!cmd_fifo_full) check("push_latency", {63'b0, cmd_fifo_inc}, 64'd1);
    endtask

    // Present one response word for one cycle.
    task automatic send_resp(input logic [33:0] w);
        resp_fifo_empty = 1'b0;
        resp_fifo_data  = w;
        @(posedge clk); #1;
        resp_fifo_empty = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [33:0] b2b [3];
        int p0, d0, s0;

        vecs[0] = '{1'b0, 34'h0,                 2'd1, 32'd456791};
        vecs[1] = '{1'b0, 34'h0,                 2'd2, 32'd76};
        vecs[2] = '{1'b0, 34'h0,                 2'd0, 32'd88};
        vecs[3] = '{1'b0, 34'h0,                 2'd3, 32'd1};
        vecs[4] = '{1'b1, {2'd3, 32'd0},         2'd3, 32'd0};
        vecs[5] = '{1'b1, {2'd2, 32'd1},         2'd2, 32'd1};
        vecs[6] = '{1'b0, 34'h0,                 2'd0, 32'd87};
        vecs[7] = '{1'b1, {2'd3, 32'd1},         2'd2, 32'd76};
        vecs[8] = '{1'b0, 34'h0,                 2'd1, 32'd456791};

        rst             = 1'b1;
        host_req_valid  = 1'b0;
        host_req_write  = 1'b0;
        host_req_addr   = 2'd0;
        host_req_wdata  = '0;
        cmd_fifo_full   = 1'b0;
        resp_fifo_empty = 1'b1;
        resp_fifo_data  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {58'b0, host_req_ready, host_rsp_valid, cmd_fifo_inc,
                             resp_fifo_inc, cur_channel, irq_data | irq_status}, 64'd0);
        check("reset_data", {host_rsp_rdata, 30'b0, cmd_fifo_data[33:32]} | {32'b0, cmd_fifo_data[31:0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_reset", {63'b0, host_req_ready}, 64'd1);
        idle(1);

        // Config write, echo, readback.
        host_req(1'b1, 2'd0, 32'd87, 32'd0);
        idle(2);
        send_resp({2'd0, 32'd87});
        host_req(1'b0, 2'd0, 32'd0, 32'd87);
        idle(1);

        // Channel write held off by a full command FIFO.
        cmd_fifo_full = 1'b1;
        host_req(1'b1, 2'd3, 32'd1, 32'd0);
        p0 = push_cnt;
        for (int i = 0; i < 5; i++) begin
            check("ready_while_full", {63'b0, host_req_ready}, 64'd0);
            check("no_push_while_full", {63'b0, cmd_fifo_inc}, 64'd0);
            @(posedge clk); #1;
        end
        cmd_fifo_full = 1'b0;
        idle(3);
        check("single_push_after_full", 64'(push_cnt - p0), 64'd1);
        check("ready_after_drain", {63'b0, host_req_ready}, 64'd1);
        send_resp({2'd3, 32'd1});
        check("cur_channel_rx", {63'b0, cur_channel}, 64'd1);

        // Back-to-back responses on the rx channel.
        b2b[0] = {2'd1, 32'd456791};
        b2b[1] = {2'd2, 32'd76};
        b2b[2] = {2'd0, 32'd88};
        p0 = pop_cnt;
        d0 = irq_data_cnt;
        s0 = irq_status_cnt;
        resp_fifo_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_fifo_data = b2b[i];
            @(negedge clk);
            check("b2b_pop", {63'b0, resp_fifo_inc}, 64'd1);
            @(posedge clk); #1;
        end
        resp_fifo_empty = 1'b1;
        idle(2);
        check("b2b_pop_count", 64'(pop_cnt - p0), 64'd3);
        check("irq_data_once", 64'(irq_data_cnt - d0), 64'd1);
        check("irq_status_once", 64'(irq_status_cnt - s0), 64'd1);

        // Table: optional response, then readback.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_resp) send_resp(vecs[i].resp);
            host_req(1'b0, vecs[i].raddr, 32'd0, vecs[i].exp_rdata);
        end
        idle(1);

        // Read in the same cycle as a status update returns the old value.
        check("ready_before_race", {63'b0, host_req_ready}, 64'd1);
        host_req_valid  = 1'b1;
        host_req_write  = 1'b0;
        host_req_addr   = 2'd2;
        resp_fifo_empty = 1'b0;
        resp_fifo_data  = {2'd2, 32'd5};
        rsp_q.push_back(32'd76);
        @(posedge clk); #1;
        host_req_valid  = 1'b0;
        resp_fifo_empty = 1'b1;
        host_req(1'b0, 2'd2, 32'd0, 32'd5);
        idle(1);

        // Reset while a command is pending and a response is at the head.
        cmd_fifo_full = 1'b1;
        host_req(1'b1, 2'd0, 32'h99, 32'd0);
        resp_fifo_empty = 1'b0;
        resp_fifo_data  = {2'd2, 32'h77};
        rst = 1'b1;
        cmd_q.delete();
        p0 = push_cnt;
        @(negedge clk);
        check("no_pop_in_reset", {63'b0, resp_fifo_inc}, 64'd0);
        check("no_ready_in_reset", {63'b0, host_req_ready}, 64'd0);
        @(posedge clk); #1;
        rst             = 1'b0;
        resp_fifo_empty = 1'b1;
        cmd_fifo_full   = 1'b0;
        idle(4);
        check("pending_discarded", 64'(push_cnt - p0), 64'd0);
        check("cur_channel_reset", {63'b0, cur_channel}, 64'd0);
        host_req(1'b0, 2'd2, 32'd0, 32'd0);
        host_req(1'b0, 2'd1, 32'd0, 32'd0);
        host_req(1'b0, 2'd0, 32'd0, 32'd0);

        // Echo watchdog: timeout, clear, mismatch (all zero when compiled out).
        host_req(1'b1, 2'd0, 32'h12, 32'd0);
        idle(70);
        host_req(1'b0, 2'd3, 32'd0, EXP_TIMEOUT_ERR);
        host_req(1'b1, 2'd3, 32'h8000_0000, 32'd0);
        idle(2);
        host_req(1'b0, 2'd3, 32'd0, 32'd0);
        host_req(1'b1, 2'd0, 32'h34, 32'd0);
        idle(2);
        send_resp({2'd0, 32'h35});
        host_req(1'b0, 2'd3, 32'd0, EXP_MISMATCH_ERR);
        host_req(1'b0, 2'd0, 32'd0, 32'h35);
        idle(3);

        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sl_host_fifo_bridge.md
Name: sl_host_fifo_bridge

Overview:
- Host-side end of the 34-bit FIFO link whose far end drives the SL transmitter/receiver config, data and status ports.
- Turns host register requests into command words {addr[1:0], data[31:0]} pushed into the command FIFO.
- Pops response words from the response FIFO into per-channel shadow registers and raises event pulses.
- The host reads all link state from these shadows; reads never cross the FIFO.

Parameters:
- WORD_W, 34, FIFO word width: 2-bit address field plus 32-bit payload.
- ECHO_TIMEOUT, 64, cycles allowed for a config echo (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- host_req_valid  in  1  host request valid
- host_req_ready  out  1  bridge can accept a request
- host_req_write  in  1  1 = write, 0 = read
- host_req_addr  in  2  0 config, 1 data, 2 status, 3 channel
- host_req_wdata  in  32  write payload
- host_rsp_valid  out  1  read data valid (one-cycle pulse)
- host_rsp_rdata  out  32  read data
- cmd_fifo_full  in  1  command FIFO full
- cmd_fifo_inc  out  1  push strobe
- cmd_fifo_data  out  34  command word
- resp_fifo_empty  in  1  response FIFO empty (first-word-fall-through)
- resp_fifo_data  in  34  response word at head
- resp_fifo_inc  out  1  pop strobe
- cur_channel  out  1  channel confirmed by the far end (0 tx, 1 rx)
- irq_data  out  1  one-cycle pulse on each rx data response
- irq_status  out  1  one-cycle pulse on each status response

Behaviour:
- Reset values:
  - All outputs 0.
  - All shadows 0; cur_channel 0; command holding register empty.
- Write path:
  - host_req_ready = !cmd_vld.
  - An accepted write loads cmd_vld and cmd_word = {host_req_addr, host_req_wdata} at the next edge.
  - While cmd_vld && !cmd_fifo_full: cmd_fifo_inc=1 and cmd_fifo_data=cmd_word; cmd_vld clears at that edge.
  - Minimum latency from accept to push is 1 cycle. A full FIFO holds the word indefinitely with no drop or duplicate.
  - Writes to data/status are forwarded unchanged; the far end discards them.
- Read path:
  - An accepted read gives host_rsp_valid=1 on the next cycle.
  - rdata by address:
    - addr 0 → {16'b0, cfg[cur_channel]}
    - addr 1 → rx_data
    - addr 2 → {16'b0, status[cur_channel]}
    - addr 3 → {err_bits[1:0], 29'b0, cur_channel}
  - Reads are also stalled while cmd_vld=1.
  - A read in the same cycle as a shadow update returns the pre-update value.
- Response path:
  - resp_fifo_inc = !resp_fifo_empty; the bridge is always ready and pops in the same cycle the word is presented.
  - Decode of a popped word:
    - addr 0 → cfg[cur_channel] ← data[15:0]
    - addr 1 → rx_data ← data; irq_data pulses next cycle
    - addr 2 → status[cur_channel] ← data[15:0]; irq_status pulses next cycle
    - addr 3 → cur_channel ← data[0]; later words in the stream apply to the new channel
  - Back-to-back words pop one per cycle.
- Reset mid-operation:
  - A pending command is discarded and any response at the head is not popped during reset.
  - The host must re-read state after reset.
- err_bits read 0 when the optional feature is compiled out.

Optional Feature:
- Macro: SL_ECHO_CHECK_EN.
- Defined:
  - A host config write arms a counter when it is pushed. The counter holds the written value[15:0].
  - The counter is disarmed by the next addr-0 response.
  - On a value mismatch, err_bits[0] (mismatch) sets sticky.
  - If ECHO_TIMEOUT cycles elapse with no echo, err_bits[1] (timeout) sets sticky.
  - A host write to addr 3 with wdata[31]=1 clears both bits; that word is still forwarded with bit 31 masked to 0.
  - A new config push re-arms the counter and restarts its count.
- Not defined: no counter is built, err_bits are constant 0, and addr-3 writes pass through unmodified.

Decomposition:
- Package sl_fifo_pkg:
  - addr_e enum (CFG=0, DATA=1, STATUS=2, CHAN=3)
  - WORD_W, PAYLOAD_W=32, CFG_W=16
  - fifo_word_t packed struct {addr_e addr; logic [31:0] data}
- Sub-module sl_echo_watchdog: timeout counter plus compare, instantiated only under SL_ECHO_CHECK_EN.

Test Plan:
- Write cfg 87, FIFO not full → cmd_fifo_inc one cycle later with cmd_fifo_data = 34'h0_00000057. Then response {0,87}, read addr 0 → rdata 87.
- Write chan 1 with cmd_fifo_full held 5 cycles → ready stays 0, exactly one push of 34'h3_00000001 after full drops. Then response {3,1} → cur_channel=1.
- Responses {1,456791},{2,76},{0,88} back-to-back while cur_channel=1:
  - three consecutive pops
  - irq_data and irq_status each pulse once
  - read addr 1/2/0 returns 456791/76/88
- Response {3,0} then {2,1} → cur_channel=0 and status[tx]=1; rx status unchanged at 76.
- Read addr 2 in the same cycle status response {2,5} pops → rdata holds the old value; the next read returns 5.
- SL_ECHO_CHECK_EN: write cfg 0x12 with no echo for 64 cycles → err_bits[1]=1. Then write chan with bit31=1 → bits clear and the forwarded word has bit31=0.
